// File: rtl/ps2_pkg.sv
// Shared PS/2 types: controller flags, decoded key events, scan code constants
// and the decoder state encoding.
package ps2_pkg;

    typedef struct packed {
        logic timeout;
        logic parity_err;
        logic stop_err;
    } flags_t;

    typedef struct packed {
        logic       pause;
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } kbd_event_t;

    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_BRK     = 8'hF0;
    localparam logic [7:0] SC_PAUSE   = 8'hE1;
    localparam logic [7:0] SC_ACK     = 8'hFA;
    localparam logic [7:0] SC_RESEND  = 8'hFE;
    localparam logic [7:0] SC_BAT_OK  = 8'hAA;
    localparam logic [7:0] SC_BAT_ERR = 8'hFC;
    localparam logic [7:0] SC_ECHO    = 8'hEE;
    localparam logic [7:0] SC_OVR0    = 8'h00;
    localparam logic [7:0] SC_OVRF    = 8'hFF;

    // Code reported for the Pause key, and bytes following E1 before it completes
    localparam logic [7:0] PAUSE_CODE = 8'h77;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } dec_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; full/empty from an extra pointer MSB.
// A push while full is ignored unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr == r_rd);
    assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + (AW+1)'(1);
            if (w_do_pop)  r_rd <= r_rd + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// Scan code set 2 decoder: turns PS/2 bytes into key events (make/break, E0, Pause),
// reports device control replies as pulses and buffers events in a FIFO.
module ps2_kbd_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic             in_is_tx,
    input  logic [7:0]       in_data,
    input  flags_t           in_flags,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_break,
    output logic             ev_pause,
    output logic             ctl_ack,
    output logic             ctl_resend,
    output logic             ctl_bat_ok,
    output logic             ctl_echo,
    output logic             ev_drop,
    output logic [ERR_W-1:0] err_count
);
    dec_state_t       r_state, w_state_nxt;
    logic [2:0]       r_skip, w_skip_nxt;
    logic             w_acc;
    logic             w_push;
    kbd_event_t       w_push_ev;
    logic             w_err_inc;
    logic             w_ack, w_resend, w_bat_ok, w_echo;
    logic             w_full, w_empty, w_pop;
    kbd_event_t       w_head;
    logic [ERR_W-1:0] r_err;
    logic             r_ack, r_resend, r_bat_ok, r_echo, r_drop;

    assign w_acc = en & in_valid & ~in_is_tx;
    assign w_pop = ~w_empty & ev_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_skip  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_skip  <= w_skip_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip;
        w_push      = 1'b0;
        w_push_ev   = '0;
        w_err_inc   = 1'b0;
        w_ack       = 1'b0;
        w_resend    = 1'b0;
        w_bat_ok    = 1'b0;
        w_echo      = 1'b0;
        if (!en) begin
            w_state_nxt = ST_IDLE;
        end else if (w_acc) begin
            if (in_flags != flags_t'('0)) begin
                w_state_nxt = ST_IDLE;
                w_err_inc   = 1'b1;
            end else if (r_state == ST_PAUSE) begin
                // Pause body carries no information, so bytes are only counted
                w_skip_nxt = r_skip - 3'd1;
                if (r_skip == 3'd1) begin
                    w_push         = 1'b1;
                    w_push_ev.pause = 1'b1;
                    w_push_ev.code  = PAUSE_CODE;
                    w_state_nxt    = ST_IDLE;
                end
            end else begin
                w_state_nxt = ST_IDLE;
                case (in_data)
                    SC_ACK:    w_ack    = 1'b1;
                    SC_RESEND: w_resend = 1'b1;
                    SC_BAT_OK: w_bat_ok = 1'b1;
                    SC_ECHO:   w_echo   = 1'b1;
                    SC_BAT_ERR, SC_OVR0, SC_OVRF: w_err_inc = 1'b1;
                    default: begin
                        case (r_state)
                            ST_IDLE: begin
                                if (in_data == SC_EXT) begin
                                    w_state_nxt = ST_EXT;
                                end else if (in_data == SC_BRK) begin
                                    w_state_nxt = ST_BRK;
                                end else if (in_data == SC_PAUSE) begin
                                    w_state_nxt = ST_PAUSE;
                                    w_skip_nxt  = PAUSE_SKIP;
                                end else begin
                                    w_push         = 1'b1;
                                    w_push_ev.code = in_data;
                                end
                            end
                            ST_EXT: begin
                                if (in_data == SC_BRK) begin
                                    w_state_nxt = ST_EXT_BRK;
                                end else begin
                                    w_push         = 1'b1;
                                    w_push_ev.ext  = 1'b1;
                                    w_push_ev.code = in_data;
                                end
                            end
                            ST_BRK, ST_EXT_BRK: begin
                                if (in_data == SC_EXT || in_data == SC_BRK || in_data == SC_PAUSE) begin
                                    w_err_inc = 1'b1;
                                end else begin
                                    w_push         = 1'b1;
                                    w_push_ev.ext  = (r_state == ST_EXT_BRK);
                                    w_push_ev.brk  = 1'b1;
                                    w_push_ev.code = in_data;
                                end
                            end
                            default: w_state_nxt = ST_IDLE;
                        endcase
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err    <= '0;
            r_ack    <= 1'b0;
            r_resend <= 1'b0;
            r_bat_ok <= 1'b0;
            r_echo   <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            if (w_err_inc && r_err != '1) r_err <= r_err + ERR_W'(1);
            r_ack    <= w_ack;
            r_resend <= w_resend;
            r_bat_ok <= w_bat_ok;
            r_echo   <= w_echo;
            r_drop   <= w_push & w_full & ~w_pop;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(kbd_event_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_ev),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Head fields are gated so that an empty FIFO presents all-zero outputs
    assign ev_valid   = ~w_empty;
    assign ev_code    = w_empty ? 8'h00 : w_head.code;
    assign ev_ext     = ~w_empty & w_head.ext;
    assign ev_break   = ~w_empty & w_head.brk;
    assign ev_pause   = ~w_empty & w_head.pause;
    assign ctl_ack    = r_ack;
    assign ctl_resend = r_resend;
    assign ctl_bat_ok = r_bat_ok;
    assign ctl_echo   = r_echo;
    assign ev_drop    = r_drop;
    assign err_count  = r_err;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Directed plus randomized bench for ps2_kbd_decoder against a prefix-flag /
// event-queue reference model; every cycle's outputs are compared.
module tb_ps2_kbd_decoder;
    import ps2_pkg::*;

    localparam int DEPTH = 4;
    localparam int ERR_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_is_tx = 1'b0;
    logic [7:0]       in_data = 8'h00;
    flags_t           in_flags = '0;
    logic             ev_valid;
    logic             ev_ready = 1'b0;
    logic [7:0]       ev_code;
    logic             ev_ext, ev_break, ev_pause;
    logic             ctl_ack, ctl_resend, ctl_bat_ok, ctl_echo;
    logic             ev_drop;
    logic [ERR_W-1:0] err_count;

    ps2_kbd_decoder #(.FIFO_DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_is_tx(in_is_tx),
        .in_data(in_data), .in_flags(in_flags), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break), .ev_pause(ev_pause),
        .ctl_ack(ctl_ack), .ctl_resend(ctl_resend), .ctl_bat_ok(ctl_bat_ok),
        .ctl_echo(ctl_echo), .ev_drop(ev_drop), .err_count(err_count)
    );

    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: pending-prefix flags, Pause bytes left, error total, event queue
    bit         m_ext, m_brk;
    int         m_pause;
    int         m_err;
    kbd_event_t mq[$];
    bit         e_ack, e_resend, e_bat, e_echo, e_drop;
    logic       g_ready = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("ev_valid", 32'(ev_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("ev_code",  32'(ev_code),  32'(mq[0].code));
            chk("ev_ext",   32'(ev_ext),   32'(mq[0].ext));
            chk("ev_break", 32'(ev_break), 32'(mq[0].brk));
            chk("ev_pause", 32'(ev_pause), 32'(mq[0].pause));
        end
        chk("ctl_ack",    32'(ctl_ack),    32'(e_ack));
        chk("ctl_resend", 32'(ctl_resend), 32'(e_resend));
        chk("ctl_bat_ok", 32'(ctl_bat_ok), 32'(e_bat));
        chk("ctl_echo",   32'(ctl_echo),   32'(e_echo));
        chk("ev_drop",    32'(ev_drop),    32'(e_drop));
        chk("err_count",  32'(err_count),  32'(m_err));
    endtask

    function automatic kbd_event_t mk(input bit p, input bit x, input bit b, input logic [7:0] c);
        kbd_event_t ev;
        ev.pause = p; ev.ext = x; ev.brk = b; ev.code = c;
        return ev;
    endfunction

    // One clock cycle: drive inputs, predict, advance, compare
    task automatic step(input logic v, input logic tx, input logic e, input logic [7:0] d,
                        input logic [2:0] f, input logic rdy);
        bit         push;
        bit         pop;
        bit         clr;
        kbd_event_t pev;
        en = e; in_valid = v; in_is_tx = tx; in_data = d; in_flags = flags_t'(f); ev_ready = rdy;
        push = 0; clr = 0; pev = '0;
        e_ack = 0; e_resend = 0; e_bat = 0; e_echo = 0;
        pop = (mq.size() > 0) && rdy;
        if (!e) begin
            clr = 1;
        end else if (v && !tx) begin
            if (f != 3'b000) begin
                m_err++; clr = 1;
            end else if (m_pause > 0) begin
                m_pause--;
                if (m_pause == 0) begin push = 1; pev = mk(1, 0, 0, 8'h77); end
            end else if (d == 8'hFA || d == 8'hFE || d == 8'hAA || d == 8'hEE) begin
                e_ack = (d == 8'hFA); e_resend = (d == 8'hFE);
                e_bat = (d == 8'hAA); e_echo = (d == 8'hEE);
                clr = 1;
            end else if (d == 8'hFC || d == 8'h00 || d == 8'hFF) begin
                m_err++; clr = 1;
            end else if (m_brk) begin
                if (d == 8'hE0 || d == 8'hF0 || d == 8'hE1) m_err++;
                else begin push = 1; pev = mk(0, m_ext, 1, d); end
                clr = 1;
            end else if (m_ext) begin
                if (d == 8'hF0) m_brk = 1;
                else begin push = 1; pev = mk(0, 1, 0, d); clr = 1; end
            end else if (d == 8'hE0) m_ext = 1;
            else if (d == 8'hF0) m_brk = 1;
            else if (d == 8'hE1) m_pause = 7;
            else begin push = 1; pev = mk(0, 0, 0, d); end
        end
        if (clr) begin m_ext = 0; m_brk = 0; m_pause = 0; end
        if (m_err > 255) m_err = 255;
        e_drop = push && (mq.size() == DEPTH) && !pop;
        if (pop) void'(mq.pop_front());
        if (push && !e_drop) mq.push_back(pev);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, 1'b0, 1'b1, d, 3'b000, g_ready);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 8'h00, 3'b000, g_ready);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; en = 1'b1; ev_ready = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0;
        m_ext = 0; m_brk = 0; m_pause = 0; m_err = 0; mq.delete();
        e_ack = 0; e_resend = 0; e_bat = 0; e_echo = 0; e_drop = 0;
        chk("rst_ev_valid",  32'(ev_valid), 32'(0));
        chk("rst_ev_code",   32'(ev_code), 32'(0));
        chk("rst_ev_flags",  32'({ev_ext, ev_break, ev_pause}), 32'(0));
        chk("rst_ctl",       32'({ctl_ack, ctl_resend, ctl_bat_ok, ctl_echo, ev_drop}), 32'(0));
        chk("rst_err_count", 32'(err_count), 32'(0));
    endtask

    logic [7:0] interesting [14] = '{8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'hFE, 8'hAA, 8'hEE,
                                     8'hFC, 8'h00, 8'hFF, 8'h1C, 8'h74, 8'h77, 8'h14};

    initial begin
        do_reset();
        g_ready = 1'b1;
        // Make then break of a plain key
        send(8'h1C); send(8'hF0); send(8'h1C); idle(2);
        // Extended make and break
        send(8'hE0); send(8'h74); send(8'hE0); send(8'hF0); send(8'h74); idle(2);
        // Pause sequence, then a normal key
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); send(8'h1C); idle(2);
        // Control replies and a BAT failure
        send(8'hFA); idle(1); send(8'hAA); idle(1); send(8'hFC); idle(2);
        send(8'hFE); send(8'hEE); idle(2);
        // Frame error drops a pending E0; tx completion is ignored
        send(8'hE0); step(1'b1, 1'b0, 1'b1, 8'h74, 3'b010, g_ready); send(8'h1C);
        step(1'b1, 1'b1, 1'b1, 8'h1C, 3'b000, g_ready); idle(2);
        // Protocol error after F0, frame error inside Pause
        send(8'hF0); send(8'hE0); send(8'h1C);
        send(8'hE1); send(8'h14); step(1'b1, 1'b0, 1'b1, 8'h77, 3'b001, g_ready); send(8'h1C);
        idle(2);
        // Overflow: fifth event dropped, then drain in order
        g_ready = 1'b0;
        send(8'h15); send(8'h16); send(8'h1D); send(8'h24); send(8'h2D); idle(2);
        // Push and pop together while full
        step(1'b1, 1'b0, 1'b1, 8'h35, 3'b000, 1'b1);
        g_ready = 1'b1; idle(6);
        // en dropped mid-prefix
        send(8'hE0); step(1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 1'b1); send(8'h74); idle(2);
        // Reset mid-prefix
        send(8'hE0);
        do_reset();
        g_ready = 1'b1;
        send(8'h74); idle(2);
        // Saturating error counter
        for (int i = 0; i < 260; i++) step(1'b1, 1'b0, 1'b1, 8'h1C, 3'b100, 1'b1);
        send(8'hFF);
        do_reset();
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] d;
            logic [2:0] f;
            d = ($urandom_range(0, 1) == 0) ? interesting[$urandom_range(0, 13)] : 8'($urandom);
            f = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 19) != 0), d, f, 1'($urandom_range(0, 9) < 6));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
